instruction_type_u_stage: RTL and testbench
===========================================

// Module: instruction_type_u_stage
// PURPOSE
//  Registered, handshaked execute stage for RISC-V U-type instructions (LUI, AUIPC).
//  Sits between decode and writeback; accepts one instruction/cycle on a valid/ready
//  input port and presents the rd index, write data and status on a valid/ready output port.
//  Generalises the combinational U-type unit: XLEN 32/64, pipeline register plus
//  2-entry skid buffer, flush, illegal-opcode flag and x0 write suppression.
// PARAMETERS
//  XLEN      32  datapath/PC width; legal values 32 or 64
//  TAG_W     4   width of the sideband tag carried alongside each instruction
// PORTS
//  iCLK      in   1        clock; all state updates on rising edge
//  iRST      in   1        synchronous reset, active-high
//  iFLUSH    in   1        synchronous pipeline flush, active-high
//  iVALID    in   1        input instruction valid
//  oREADY    out  1        stage can accept an instruction this cycle
//  iIR       in   32       instruction word
//  iPC       in   XLEN     PC of the instruction
//  iTAG      in   TAG_W    sideband tag, passed through unchanged
//  oVALID    out  1        output result valid
//  iREADY    in   1        downstream accepts result this cycle
//  oRD       out  5        destination register index, iIR[11:7]
//  oREG_IN   out  XLEN     result to write to rd
//  oWE       out  1        register write enable for this result
//  oILLEGAL  out  1        opcode was neither LUI nor AUIPC
//  oTAG      out  TAG_W    tag of the presented result
// BEHAVIOUR
//  - Input transfer when iVALID&&oREADY; output transfer when oVALID&&iREADY.
//  - Arithmetic, computed on input side:
//    imm = sign-extend {iIR[31:12],12'h000} to XLEN
//    (XLEN=32: plain shift; XLEN=64: bits 63:32 = iIR[31]).
//  - Opcode 7'h37 LUI: result = imm. Opcode 7'h17 AUIPC: result = (iPC + imm) mod 2^XLEN,
//    wrap-around with no carry-out.
//  - Any other opcode: result = 0, oILLEGAL=1, oWE=0.
//  - oWE = legal && (rd != 0); result and oRD are still presented when rd == 0.
//  - Storage: output register OUT plus skid register SKB; each entry holds
//    {rd, result, we, illegal, tag, valid}.
//  - States:
//    EMPTY: OUT invalid, SKB invalid.
//    ONE: OUT valid, SKB invalid.
//    FULL: both valid.
//  - oVALID = OUT.valid; oREADY = !SKB.valid (registered, no comb path from iREADY).
//  - EMPTY: accept -> ONE (data into OUT).
//  - ONE: accept & drain -> ONE (new into OUT); accept & !drain -> FULL (new into SKB);
//    drain & !accept -> EMPTY.
//  - FULL: drain -> ONE (SKB moves to OUT); no accept possible; otherwise hold.
//  - Latency: 1 cycle input-to-oVALID from EMPTY; sustained throughput 1/cycle with
//    iREADY=1; zero loss/duplication under arbitrary iREADY stalls.
//  - Outputs are stable while oVALID && !iREADY.
//  - iRST or iFLUSH: next edge -> EMPTY; oVALID=0, oREADY=1, oRD=0, oREG_IN=0,
//    oWE=0, oILLEGAL=0, oTAG=0.
//    Flush beats a simultaneous accept (input dropped) and drain (considered not
//    transferred upstream of writeback).
//  - Reset mid-stall discards both entries. iRST has priority over iFLUSH
//    (identical effect).
//  - Data-path outputs are zero whenever oVALID=0.
// TESTING
//  1. LUI x5, 0x12345 (iIR=32'h123452B7), iREADY=1
//     -> next cycle oVALID=1, oRD=5, oREG_IN=32'h12345000, oWE=1, oILLEGAL=0.
//  2. AUIPC x1, 0xFFFFF at iPC=32'h00001000, XLEN=32
//     -> oREG_IN=32'h00000000 (wrap); XLEN=64 with iPC=64'h1000
//     -> oREG_IN=64'h0000_0000_0000_0000, and LUI 0x80000 -> 64'hFFFFFFFF_80000000.
//  3. Back-to-back 3 instrs, iREADY held 0 for 3 cycles
//     -> oREADY drops after 2nd accept; releasing iREADY delivers tags 0,1,2
//     in order, then third in next cycle.
//  4. LUI x0, 0x1 -> oWE=0, oREG_IN=32'h00001000;
//     iIR=32'h00000033 (ADD) -> oILLEGAL=1, oWE=0, oREG_IN=0.
//  5. FULL state, then iFLUSH=1 with iVALID=1
//     -> next cycle oVALID=0, oREADY=1, flushed input never appears on the output.
//  6. iRST asserted during a stall -> all outputs zero next edge;
//     first post-reset instruction emerges with 1-cycle latency.

Source files
------------

// File: rtl/instruction_type_u_stage.sv
// Registered execute stage for RISC-V U-type instructions (LUI, AUIPC).
// Output register plus one skid entry give full throughput with a registered oREADY.
module instruction_type_u_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 4
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iFLUSH,
    input  logic             iVALID,
    output logic             oREADY,
    input  logic [31:0]      iIR,
    input  logic [XLEN-1:0]  iPC,
    input  logic [TAG_W-1:0] iTAG,
    output logic             oVALID,
    input  logic             iREADY,
    output logic [4:0]       oRD,
    output logic [XLEN-1:0]  oREG_IN,
    output logic             oWE,
    output logic             oILLEGAL,
    output logic [TAG_W-1:0] oTAG
);

    localparam logic [6:0] OpLui   = 7'h37;
    localparam logic [6:0] OpAuipc = 7'h17;

    typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

    state_e             state_q;

    logic [4:0]         out_rd_q;
    logic [XLEN-1:0]    out_res_q;
    logic               out_we_q;
    logic               out_ill_q;
    logic [TAG_W-1:0]   out_tag_q;

    logic [4:0]         skb_rd_q;
    logic [XLEN-1:0]    skb_res_q;
    logic               skb_we_q;
    logic               skb_ill_q;
    logic [TAG_W-1:0]   skb_tag_q;

    logic [XLEN-1:0]    imm;
    logic [XLEN-1:0]    new_res;
    logic               new_ill;
    logic               new_we;
    logic [4:0]         new_rd;
    logic               accept;
    logic               drain;

    assign oVALID   = (state_q != StEmpty);
    assign oREADY   = (state_q != StFull);
    assign oRD      = out_rd_q;
    assign oREG_IN  = out_res_q;
    assign oWE      = out_we_q;
    assign oILLEGAL = out_ill_q;
    assign oTAG     = out_tag_q;

    assign accept = iVALID && oREADY;
    assign drain  = oVALID && iREADY;
    assign new_rd = iIR[11:7];

    always_comb begin
        // Upper bits replicate iIR[31]; low 32 bits overwritten with the shifted immediate.
        imm       = {XLEN{iIR[31]}};
        imm[31:0] = {iIR[31:12], 12'h000};
        new_res   = '0;
        new_ill   = 1'b0;
        case (iIR[6:0])
            OpLui:   new_res = imm;
            OpAuipc: new_res = iPC + imm;
            default: new_ill = 1'b1;
        endcase
        new_we = !new_ill && (new_rd != 5'd0);
    end

    always_ff @(posedge iCLK) begin
        if (iRST || iFLUSH) begin
            state_q   <= StEmpty;
            out_rd_q  <= '0;
            out_res_q <= '0;
            out_we_q  <= 1'b0;
            out_ill_q <= 1'b0;
            out_tag_q <= '0;
            skb_rd_q  <= '0;
            skb_res_q <= '0;
            skb_we_q  <= 1'b0;
            skb_ill_q <= 1'b0;
            skb_tag_q <= '0;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (accept) begin
                        state_q   <= StOne;
                        out_rd_q  <= new_rd;
                        out_res_q <= new_res;
                        out_we_q  <= new_we;
                        out_ill_q <= new_ill;
                        out_tag_q <= iTAG;
                    end
                end
                StOne: begin
                    if (accept && drain) begin
                        out_rd_q  <= new_rd;
                        out_res_q <= new_res;
                        out_we_q  <= new_we;
                        out_ill_q <= new_ill;
                        out_tag_q <= iTAG;
                    end else if (accept) begin
                        state_q   <= StFull;
                        skb_rd_q  <= new_rd;
                        skb_res_q <= new_res;
                        skb_we_q  <= new_we;
                        skb_ill_q <= new_ill;
                        skb_tag_q <= iTAG;
                    end else if (drain) begin
                        // Clear so data outputs read zero while oVALID is low.
                        state_q   <= StEmpty;
                        out_rd_q  <= '0;
                        out_res_q <= '0;
                        out_we_q  <= 1'b0;
                        out_ill_q <= 1'b0;
                        out_tag_q <= '0;
                    end
                end
                StFull: begin
                    if (drain) begin
                        state_q   <= StOne;
                        out_rd_q  <= skb_rd_q;
                        out_res_q <= skb_res_q;
                        out_we_q  <= skb_we_q;
                        out_ill_q <= skb_ill_q;
                        out_tag_q <= skb_tag_q;
                        skb_rd_q  <= '0;
                        skb_res_q <= '0;
                        skb_we_q  <= 1'b0;
                        skb_ill_q <= 1'b0;
                        skb_tag_q <= '0;
                    end
                end
                default: state_q <= StEmpty;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_type_u_stage.sv
// Directed bench for instruction_type_u_stage; a 32-bit and a 64-bit instance share stimulus.
module tb_instruction_type_u_stage;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready;
    logic [31:0] ir;
    logic [31:0] pc32;
    logic [63:0] pc64;
    logic [3:0]  tag;

    logic        o_ready, o_valid, o_we, o_ill;
    logic [4:0]  o_rd;
    logic [31:0] o_res;
    logic [3:0]  o_tag;

    logic        o64_ready, o64_valid, o64_we, o64_ill;
    logic [4:0]  o64_rd;
    logic [63:0] o64_res;
    logic [3:0]  o64_tag;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    instruction_type_u_stage #(.XLEN(32), .TAG_W(4)) dut (
        .iCLK(clk), .iRST(rst), .iFLUSH(flush), .iVALID(in_valid), .oREADY(o_ready),
        .iIR(ir), .iPC(pc32), .iTAG(tag), .oVALID(o_valid), .iREADY(in_ready),
        .oRD(o_rd), .oREG_IN(o_res), .oWE(o_we), .oILLEGAL(o_ill), .oTAG(o_tag)
    );

    instruction_type_u_stage #(.XLEN(64), .TAG_W(4)) dut64 (
        .iCLK(clk), .iRST(rst), .iFLUSH(flush), .iVALID(in_valid), .oREADY(o64_ready),
        .iIR(ir), .iPC(pc64), .iTAG(tag), .oVALID(o64_valid), .iREADY(in_ready),
        .oRD(o64_rd), .oREG_IN(o64_res), .oWE(o64_we), .oILLEGAL(o64_ill), .oTAG(o64_tag)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] p,
                         input logic [3:0] t);
        in_valid = v;
        ir       = i;
        pc32     = p;
        pc64     = {32'h0, p};
        tag      = t;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_ready = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 4'h0);
        step(); step();
        rst = 1'b0;
        tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", o_valid); end
        tests++; if (o_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b exp 1", o_ready); end
        tests++; if ({o_rd, o_res, o_we, o_ill, o_tag} !== 42'h0) begin
            fails++; $display("FAIL reset_data got rd=%0d res=%h we=%b ill=%b tag=%0d exp all 0",
                              o_rd, o_res, o_we, o_ill, o_tag);
        end
    endtask

    task automatic test_lui();
        in_ready = 1'b1;
        drive(1'b1, 32'h123452B7, 32'h0, 4'h3);
        step();
        drive(1'b0, 32'h0, 32'h0, 4'h0);
        tests++; if (o_valid !== 1'b1) begin fails++; $display("FAIL lui_valid got %b exp 1", o_valid); end
        tests++; if (o_rd !== 5'd5) begin fails++; $display("FAIL lui_rd got %0d exp 5", o_rd); end
        tests++; if (o_res !== 32'h12345000) begin fails++; $display("FAIL lui_res got %h exp 12345000", o_res); end
        tests++; if (o_we !== 1'b1 || o_ill !== 1'b0) begin
            fails++; $display("FAIL lui_we_ill got we=%b ill=%b exp we=1 ill=0", o_we, o_ill);
        end
        tests++; if (o_tag !== 4'h3) begin fails++; $display("FAIL lui_tag got %0d exp 3", o_tag); end
        step();
        tests++; if (o_valid !== 1'b0 || o_res !== 32'h0) begin
            fails++; $display("FAIL lui_drained got valid=%b res=%h exp valid=0 res=0", o_valid, o_res);
        end
    endtask

    task automatic test_auipc();
        in_ready = 1'b1;
        drive(1'b1, 32'hFFFFF097, 32'h00001000, 4'h1);
        step();
        tests++; if (o_res !== 32'h0) begin fails++; $display("FAIL auipc32_wrap got %h exp 00000000", o_res); end
        tests++; if (o64_res !== 64'h0) begin fails++; $display("FAIL auipc64_wrap got %h exp 0", o64_res); end
        tests++; if (o_rd !== 5'd1 || o_we !== 1'b1) begin
            fails++; $display("FAIL auipc_rd_we got rd=%0d we=%b exp rd=1 we=1", o_rd, o_we);
        end
        drive(1'b1, 32'h80000137, 32'h00001000, 4'h2);
        step();
        tests++; if (o64_res !== 64'hFFFFFFFF_80000000) begin
            fails++; $display("FAIL lui64_sext got %h exp ffffffff80000000", o64_res);
        end
        tests++; if (o_res !== 32'h80000000) begin fails++; $display("FAIL lui32_neg got %h exp 80000000", o_res); end
        drive(1'b1, 32'h00010197, 32'h00000100, 4'h4);
        step();
        tests++; if (o_res !== 32'h00010100) begin fails++; $display("FAIL auipc32_add got %h exp 00010100", o_res); end
        tests++; if (o64_res !== 64'h10100) begin fails++; $display("FAIL auipc64_add got %h exp 10100", o64_res); end
        drive(1'b0, 32'h0, 32'h0, 4'h0);
        step();
    endtask

    task automatic test_x0_illegal();
        in_ready = 1'b1;
        drive(1'b1, 32'h00001037, 32'h0, 4'h5);
        step();
        tests++; if (o_we !== 1'b0 || o_res !== 32'h00001000 || o_rd !== 5'd0) begin
            fails++; $display("FAIL lui_x0 got we=%b res=%h rd=%0d exp we=0 res=00001000 rd=0",
                              o_we, o_res, o_rd);
        end
        drive(1'b1, 32'h00000033, 32'h0, 4'h6);
        step();
        tests++; if (o_ill !== 1'b1 || o_we !== 1'b0 || o_res !== 32'h0) begin
            fails++; $display("FAIL illegal_add got ill=%b we=%b res=%h exp ill=1 we=0 res=0",
                              o_ill, o_we, o_res);
        end
        drive(1'b1, 32'h00A00293, 32'h00000040, 4'h7);
        step();
        tests++; if (o_ill !== 1'b1 || o_we !== 1'b0 || o_rd !== 5'd5 || o64_res !== 64'h0) begin
            fails++; $display("FAIL illegal_addi got ill=%b we=%b rd=%0d res=%h exp ill=1 we=0 rd=5 res=0",
                              o_ill, o_we, o_rd, o64_res);
        end
        drive(1'b0, 32'h0, 32'h0, 4'h0);
        step();
    endtask

    task automatic test_back_to_back();
        in_ready = 1'b0;
        drive(1'b1, 32'h000010B7, 32'h0, 4'h0);
        step();
        tests++; if (o_ready !== 1'b1 || o_tag !== 4'h0 || o_valid !== 1'b1) begin
            fails++; $display("FAIL b2b_first got ready=%b valid=%b tag=%0d exp 1 1 0", o_ready, o_valid, o_tag);
        end
        drive(1'b1, 32'h00002137, 32'h0, 4'h1);
        step();
        tests++; if (o_ready !== 1'b0) begin fails++; $display("FAIL b2b_full_ready got %b exp 0", o_ready); end
        drive(1'b1, 32'h000031B7, 32'h0, 4'h2);
        step();
        tests++; if (o_tag !== 4'h0 || o_res !== 32'h00001000 || o_ready !== 1'b0) begin
            fails++; $display("FAIL b2b_stable got tag=%0d res=%h ready=%b exp tag=0 res=00001000 ready=0",
                              o_tag, o_res, o_ready);
        end
        in_ready = 1'b1;
        step();
        tests++; if (o_tag !== 4'h1 || o_res !== 32'h00002000 || o_ready !== 1'b1) begin
            fails++; $display("FAIL b2b_second got tag=%0d res=%h ready=%b exp tag=1 res=00002000 ready=1",
                              o_tag, o_res, o_ready);
        end
        step();
        drive(1'b0, 32'h0, 32'h0, 4'h0);
        tests++; if (o_tag !== 4'h2 || o_res !== 32'h00003000 || o_rd !== 5'd3) begin
            fails++; $display("FAIL b2b_third got tag=%0d res=%h rd=%0d exp tag=2 res=00003000 rd=3",
                              o_tag, o_res, o_rd);
        end
        step();
        tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL b2b_empty got %b exp 0", o_valid); end
    endtask

    task automatic test_flush();
        in_ready = 1'b0;
        drive(1'b1, 32'h000010B7, 32'h0, 4'h1);
        step();
        drive(1'b1, 32'h00002137, 32'h0, 4'h2);
        step();
        flush = 1'b1; in_ready = 1'b1;
        drive(1'b1, 32'h000031B7, 32'h0, 4'h7);
        step();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 4'h0);
        tests++; if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_tag !== 4'h0 || o_res !== 32'h0) begin
            fails++; $display("FAIL flush_full got valid=%b ready=%b tag=%0d res=%h exp 0 1 0 0",
                              o_valid, o_ready, o_tag, o_res);
        end
        step();
        tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL flush_no_leak got %b exp 0", o_valid); end
        drive(1'b1, 32'h000010B7, 32'h0, 4'h5);
        step();
        flush = 1'b1;
        drive(1'b1, 32'h00002137, 32'h0, 4'h6);
        step();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 4'h0);
        tests++; if (o_valid !== 1'b0 || o_tag !== 4'h0) begin
            fails++; $display("FAIL flush_one got valid=%b tag=%0d exp 0 0", o_valid, o_tag);
        end
        step();
        tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL flush_one_no_leak got %b exp 0", o_valid); end
    endtask

    task automatic test_reset_stall();
        in_ready = 1'b0;
        drive(1'b1, 32'h000010B7, 32'h0, 4'h1);
        step();
        drive(1'b1, 32'h00002137, 32'h0, 4'h2);
        step();
        rst = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 4'h0);
        step();
        rst = 1'b0;
        tests++; if (o_valid !== 1'b0 || o_ready !== 1'b1 ||
                     {o_rd, o_res, o_we, o_ill, o_tag} !== 42'h0) begin
            fails++; $display("FAIL rst_stall got valid=%b ready=%b rd=%0d res=%h tag=%0d exp 0 1 0 0 0",
                              o_valid, o_ready, o_rd, o_res, o_tag);
        end
        in_ready = 1'b1;
        drive(1'b1, 32'h123452B7, 32'h0, 4'h9);
        step();
        drive(1'b0, 32'h0, 32'h0, 4'h0);
        tests++; if (o_valid !== 1'b1 || o_tag !== 4'h9 || o_res !== 32'h12345000) begin
            fails++; $display("FAIL rst_first got valid=%b tag=%0d res=%h exp 1 9 12345000",
                              o_valid, o_tag, o_res);
        end
        step();
        tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL rst_first_drain got %b exp 0", o_valid); end
    endtask

    initial begin
        test_reset();
        test_lui();
        test_auipc();
        test_x0_illegal();
        test_back_to_back();
        test_flush();
        test_reset_stall();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
